mc_controller_fsm: RTL and testbench

MC_CONTROLLER_FSM -- requirements
Module: mc_controller_fsm

---
 rtl/riscv_ctrl_pkg.sv | 58 +++++
 rtl/imm_src_dec.sv | 22 ++
 rtl/mc_controller_fsm.sv | 181 ++++++++++++++++++
 tb/tb_mc_controller_fsm.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: FSM states,
// opcodes and the encodings of every datapath select the controller drives.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_LUI,
      S_TRAP
   } ctrlState_t;

   // Opcodes understood by the controller
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU operand A: current PC, PC of the instruction being executed, rs1, zero
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B: rs2, immediate, constant four
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux: registered ALU output, memory read data, live ALU result
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // ALU decoder hint: add, subtract (compare), decode from funct fields
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-format decoder; purely a function of the opcode so the datapath
// sees the right extension whatever state the controller is in.
module imm_src_dec
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   output logic [2:0] immSrc_o
);

   // Map opcode to immediate format, I-type layout for anything unrecognised
   always_comb begin
      immSrc_o = IMM_I;
      case (op_i)
         OP_STORE:  immSrc_o = IMM_S;
         OP_BRANCH: immSrc_o = IMM_B;
         OP_JAL:    immSrc_o = IMM_J;
         OP_LUI:    immSrc_o = IMM_U;
         default:   immSrc_o = IMM_I;
      endcase
   end

endmodule

// File: rtl/mc_controller_fsm.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode and
// execute phases, plus a retired-instruction counter and a sticky trap flag.
module mc_controller_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned EN_LUI = 1,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCUpdate,
   output logic             Branch,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [2:0]       ImmSrc,
   output logic             retire,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             illegal
);

   ctrlState_t       state_q, state_d;
   logic [CNT_W-1:0] retiredCnt_q;
   logic             illegal_q;

   imm_src_dec uImmSrcDec (
      .op_i     (op),
      .immSrc_o (ImmSrc)
   );

   // State register; reset drops straight back to FETCH, abandoning any access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and Moore outputs; strobes are masked while reset is held
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_REG;
      ALUOp     = ALUOP_ADD;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            IRWrite   = mem_ready;
            PCUpdate  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = (EN_LUI != 0) ? S_LUI : S_TRAP;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            retire   = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_REG;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_REG;
            ALUOp   = ALUOP_SUB;
            Branch  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA  = SRCA_OLDPC;
            ALUSrcB  = SRCB_FOUR;
            PCUpdate = 1'b1;
            state_d  = S_ALUWB;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
            state_d = S_ALUWB;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      if (!reset_n) begin
         mem_req  = 1'b0;
         IRWrite  = 1'b0;
         PCUpdate = 1'b0;
         Branch   = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         retire   = 1'b0;
      end
   end

   // Retired-instruction counter, wraps naturally at its width
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retiredCnt_q <= '0;
      end else if (retire) begin
         retiredCnt_q <= retiredCnt_q + CNT_W'(1);
      end
   end

   // Sticky unsupported-opcode flag, raised on the edge that enters TRAP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         illegal_q <= 1'b0;
      end else if (state_d == S_TRAP) begin
         illegal_q <= 1'b1;
      end
   end

   assign retired_cnt = retiredCnt_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_controller_fsm.sv
// Directed testbench for mc_controller_fsm: walks each instruction class
// through the FSM and compares every cycle's outputs to hand-derived values.
module tb_mc_controller_fsm;

   localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                  MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9,
                  JAL = 10, LUI = 11, TRAP = 12;

   // Output signature while reset is held: FETCH selects, every strobe low
   localparam logic [16:0] RST_SIG = 17'b0_0_0_0_0_0_0_10_00_10_00_0_0;

   logic clk = 1'b0;
   logic reset_n;
   logic mem_ready;
   logic [6:0] op;

   logic mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;
   logic retire, illegal;
   logic [31:0] retired_cnt;

   logic nlMemReq, nlAdrSrc, nlIRWrite, nlPCUpdate, nlBranch, nlRegWrite, nlMemWrite;
   logic [1:0] nlResultSrc, nlALUSrcA, nlALUSrcB, nlALUOp;
   logic [2:0] nlImmSrc;
   logic nlRetire, nlIllegal;
   logic [31:0] nlRetiredCnt;

   logic smMemReq, smAdrSrc, smIRWrite, smPCUpdate, smBranch, smRegWrite, smMemWrite;
   logic [1:0] smResultSrc, smALUSrcA, smALUSrcB, smALUOp;
   logic [2:0] smImmSrc;
   logic smRetire, smIllegal;
   logic [3:0] smRetiredCnt;

   logic [16:0] sig, nlSig;

   int compared = 0;
   int mismatched = 0;
   int expCnt = 0;

   always #5 clk = ~clk;

   assign sig = {mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, retire, illegal};
   assign nlSig = {nlMemReq, nlAdrSrc, nlIRWrite, nlPCUpdate, nlBranch, nlRegWrite,
                   nlMemWrite, nlResultSrc, nlALUSrcA, nlALUSrcB, nlALUOp,
                   nlRetire, nlIllegal};

   mc_controller_fsm dut (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
      .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .ImmSrc(ImmSrc), .retire(retire), .retired_cnt(retired_cnt), .illegal(illegal)
   );

   mc_controller_fsm #(.EN_LUI(0)) dutNoLui (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .mem_req(nlMemReq), .AdrSrc(nlAdrSrc), .IRWrite(nlIRWrite), .PCUpdate(nlPCUpdate),
      .Branch(nlBranch), .RegWrite(nlRegWrite), .MemWrite(nlMemWrite),
      .ResultSrc(nlResultSrc), .ALUSrcA(nlALUSrcA), .ALUSrcB(nlALUSrcB), .ALUOp(nlALUOp),
      .ImmSrc(nlImmSrc), .retire(nlRetire), .retired_cnt(nlRetiredCnt), .illegal(nlIllegal)
   );

   mc_controller_fsm #(.CNT_W(4)) dutSmall (
      .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
      .mem_req(smMemReq), .AdrSrc(smAdrSrc), .IRWrite(smIRWrite), .PCUpdate(smPCUpdate),
      .Branch(smBranch), .RegWrite(smRegWrite), .MemWrite(smMemWrite),
      .ResultSrc(smResultSrc), .ALUSrcA(smALUSrcA), .ALUSrcB(smALUSrcB), .ALUOp(smALUOp),
      .ImmSrc(smImmSrc), .retire(smRetire), .retired_cnt(smRetiredCnt), .illegal(smIllegal)
   );

   // Expected Moore output signature for a state, given the mem_ready level
   function automatic logic [16:0] expSig(int st, bit rdy);
      logic memReq, adr, irw, pcu, br, rw, mw, ret, ill;
      logic [1:0] rs, sa, sb, aop;
      memReq = 0; adr = 0; irw = 0; pcu = 0; br = 0; rw = 0; mw = 0; ret = 0; ill = 0;
      rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
      case (st)
         FETCH:    begin memReq = 1; irw = rdy; pcu = rdy; rs = 2'b10; sb = 2'b10; end
         DECODE:   begin sa = 2'b01; sb = 2'b01; end
         MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         MEMREAD:  begin memReq = 1; adr = 1; end
         MEMWB:    begin rs = 2'b01; rw = 1; ret = 1; end
         MEMWRITE: begin memReq = 1; adr = 1; mw = 1; ret = rdy; end
         EXECR:    begin sa = 2'b10; aop = 2'b10; end
         EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         ALUWB:    begin rw = 1; ret = 1; end
         BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1; ret = 1; end
         JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1; end
         LUI:      begin sa = 2'b11; sb = 2'b01; end
         TRAP:     begin ill = 1; end
         default:  ;
      endcase
      return {memReq, adr, irw, pcu, br, rw, mw, rs, sa, sb, aop, ret, ill};
   endfunction

   // Reset values, forced strobes with mem_ready high, then FETCH on release
   task automatic test_reset();
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      compared++;
      if (sig !== RST_SIG) begin
         mismatched++; $display("[TB] FAIL reset_sig got=%b want=%b", sig, RST_SIG);
      end
      compared++;
      if (retired_cnt !== 32'd0) begin
         mismatched++; $display("[TB] FAIL reset_cnt got=%0d want=0", retired_cnt);
      end
      reset_n = 1'b1;
      #1;
      compared++;
      if (sig !== expSig(FETCH, 1'b1)) begin
         mismatched++; $display("[TB] FAIL reset_release got=%b want=%b", sig, expSig(FETCH, 1'b1));
      end
      mem_ready = 1'b0;
   endtask

   // lw with mem_ready high in the memory states; low in DECODE/MEMADR must be ignored
   task automatic test_lw();
      int st[$]; bit rd[$]; logic [16:0] e;
      st = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
      rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < st.size(); i++) begin
         @(negedge clk);
         op = 7'b0000011; mem_ready = rd[i];
         #1;
         e = expSig(st[i], rd[i]);
         compared++;
         if (sig !== e) begin
            mismatched++; $display("[TB] FAIL lw_step%0d got=%b want=%b", i, sig, e);
         end
         compared++;
         if (retired_cnt !== 32'(expCnt)) begin
            mismatched++; $display("[TB] FAIL lw_cnt%0d got=%0d want=%0d", i, retired_cnt, expCnt);
         end
         if (e[1]) expCnt++;
      end
      compared++;
      if (ImmSrc !== 3'b000) begin
         mismatched++; $display("[TB] FAIL lw_imm got=%b want=000", ImmSrc);
      end
   endtask

   // sw stalled three cycles in MEMWRITE: four MemWrite cycles, one retire
   task automatic test_sw_wait();
      int st[$]; bit rd[$]; logic [16:0] e; int mwCount, retCount;
      st = '{FETCH, DECODE, MEMADR, MEMWRITE, MEMWRITE, MEMWRITE, MEMWRITE};
      rd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      mwCount = 0; retCount = 0;
      for (int i = 0; i < st.size(); i++) begin
         @(negedge clk);
         op = 7'b0100011; mem_ready = rd[i];
         #1;
         e = expSig(st[i], rd[i]);
         compared++;
         if (sig !== e) begin
            mismatched++; $display("[TB] FAIL sw_step%0d got=%b want=%b", i, sig, e);
         end
         compared++;
         if (retired_cnt !== 32'(expCnt)) begin
            mismatched++; $display("[TB] FAIL sw_cnt%0d got=%0d want=%0d", i, retired_cnt, expCnt);
         end
         compared++;
         if (ImmSrc !== 3'b001) begin
            mismatched++; $display("[TB] FAIL sw_imm%0d got=%b want=001", i, ImmSrc);
         end
         if (MemWrite) mwCount++;
         if (retire) retCount++;
         if (e[1]) expCnt++;
      end
      compared++;
      if (mwCount !== 4) begin
         mismatched++; $display("[TB] FAIL sw_memwrite_cycles got=%0d want=4", mwCount);
      end
      compared++;
      if (retCount !== 1) begin
         mismatched++; $display("[TB] FAIL sw_retire_pulses got=%0d want=1", retCount);
      end
   endtask

   // R-type after a two-cycle fetch stall, then an I-type back to back
   task automatic test_alu();
      int st[$]; bit rd[$]; logic [6:0] ops[$]; logic [16:0] e;
      st  = '{FETCH, FETCH, FETCH, DECODE, EXECR, ALUWB, FETCH, DECODE, EXECI, ALUWB};
      rd  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      ops = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
              7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011};
      for (int i = 0; i < st.size(); i++) begin
         @(negedge clk);
         op = ops[i]; mem_ready = rd[i];
         #1;
         e = expSig(st[i], rd[i]);
         compared++;
         if (sig !== e) begin
            mismatched++; $display("[TB] FAIL alu_step%0d got=%b want=%b", i, sig, e);
         end
         compared++;
         if (retired_cnt !== 32'(expCnt)) begin
            mismatched++; $display("[TB] FAIL alu_cnt%0d got=%0d want=%0d", i, retired_cnt, expCnt);
         end
         if (e[1]) expCnt++;
      end
   endtask

   // beq (3 cycles) followed by jal (4 cycles), with their immediate formats
   task automatic test_beq_jal();
      int st[$]; logic [6:0] ops[$]; logic [2:0] im[$]; logic [16:0] e;
      st  = '{FETCH, DECODE, BEQ, FETCH, DECODE, JAL, ALUWB};
      ops = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
      im  = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b011};
      for (int i = 0; i < st.size(); i++) begin
         @(negedge clk);
         op = ops[i]; mem_ready = 1'b1;
         #1;
         e = expSig(st[i], 1'b1);
         compared++;
         if (sig !== e) begin
            mismatched++; $display("[TB] FAIL bj_step%0d got=%b want=%b", i, sig, e);
         end
         compared++;
         if (ImmSrc !== im[i]) begin
            mismatched++; $display("[TB] FAIL bj_imm%0d got=%b want=%b", i, ImmSrc, im[i]);
         end
         compared++;
         if (retired_cnt !== 32'(expCnt)) begin
            mismatched++; $display("[TB] FAIL bj_cnt%0d got=%0d want=%0d", i, retired_cnt, expCnt);
         end
         if (e[1]) expCnt++;
      end
   endtask

   // lui executes when enabled and traps in the instance built without it
   task automatic test_lui();
      int st[$]; int nst[$]; logic [16:0] e, ne;
      st  = '{FETCH, DECODE, LUI, ALUWB};
      nst = '{FETCH, DECODE, TRAP, TRAP};
      for (int i = 0; i < st.size(); i++) begin
         @(negedge clk);
         op = 7'b0110111; mem_ready = 1'b1;
         #1;
         e  = expSig(st[i], 1'b1);
         ne = expSig(nst[i], 1'b1);
         compared++;
         if (sig !== e) begin
            mismatched++; $display("[TB] FAIL lui_step%0d got=%b want=%b", i, sig, e);
         end
         compared++;
         if (nlSig !== ne) begin
            mismatched++; $display("[TB] FAIL lui_off_step%0d got=%b want=%b", i, nlSig, ne);
         end
         compared++;
         if (ImmSrc !== 3'b100) begin
            mismatched++; $display("[TB] FAIL lui_imm%0d got=%b want=100", i, ImmSrc);
         end
         if (e[1]) expCnt++;
      end
   endtask

   // Unsupported opcode traps, stays trapped through later opcodes, clears on reset
   task automatic test_trap();
      int st[$]; bit rd[$]; logic [6:0] ops[$]; logic [16:0] e;
      st  = '{FETCH, DECODE, TRAP, TRAP, TRAP, TRAP};
      rd  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      ops = '{7'b1110011, 7'b1110011, 7'b1110011, 7'b0000011, 7'b0110011, 7'b1100011};
      for (int i = 0; i < st.size(); i++) begin
         @(negedge clk);
         op = ops[i]; mem_ready = rd[i];
         #1;
         e = expSig(st[i], rd[i]);
         compared++;
         if (sig !== e) begin
            mismatched++; $display("[TB] FAIL trap_step%0d got=%b want=%b", i, sig, e);
         end
         compared++;
         if (retired_cnt !== 32'(expCnt)) begin
            mismatched++; $display("[TB] FAIL trap_cnt%0d got=%0d want=%0d", i, retired_cnt, expCnt);
         end
      end
      reset_n = 1'b0; mem_ready = 1'b1;
      #1;
      expCnt = 0;
      compared++;
      if (sig !== RST_SIG) begin
         mismatched++; $display("[TB] FAIL trap_reset_sig got=%b want=%b", sig, RST_SIG);
      end
      compared++;
      if (nlIllegal !== 1'b0) begin
         mismatched++; $display("[TB] FAIL trap_reset_nolui_illegal got=%b want=0", nlIllegal);
      end
      compared++;
      if (retired_cnt !== 32'd0) begin
         mismatched++; $display("[TB] FAIL trap_reset_cnt got=%0d want=0", retired_cnt);
      end
      reset_n = 1'b1;
      #1;
      compared++;
      if (sig !== expSig(FETCH, 1'b1)) begin
         mismatched++; $display("[TB] FAIL trap_release got=%b want=%b", sig, expSig(FETCH, 1'b1));
      end
      mem_ready = 1'b0;
   endtask

   // Reset asserted while lw waits in MEMREAD: strobes drop at once, no retire
   task automatic test_reset_mid();
      int st[$]; bit rd[$]; logic [16:0] e;
      st = '{FETCH, DECODE, MEMADR, MEMREAD, MEMREAD};
      rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < st.size(); i++) begin
         @(negedge clk);
         op = 7'b0000011; mem_ready = rd[i];
         #1;
         e = expSig(st[i], rd[i]);
         compared++;
         if (sig !== e) begin
            mismatched++; $display("[TB] FAIL rmid_step%0d got=%b want=%b", i, sig, e);
         end
      end
      reset_n = 1'b0; mem_ready = 1'b1;
      #1;
      compared++;
      if (sig !== RST_SIG) begin
         mismatched++; $display("[TB] FAIL rmid_async got=%b want=%b", sig, RST_SIG);
      end
      @(negedge clk);
      #1;
      compared++;
      if (sig !== RST_SIG) begin
         mismatched++; $display("[TB] FAIL rmid_held got=%b want=%b", sig, RST_SIG);
      end
      compared++;
      if (retired_cnt !== 32'd0) begin
         mismatched++; $display("[TB] FAIL rmid_cnt got=%0d want=0", retired_cnt);
      end
      reset_n = 1'b1;
      #1;
      compared++;
      if (sig !== expSig(FETCH, 1'b1)) begin
         mismatched++; $display("[TB] FAIL rmid_release got=%b want=%b", sig, expSig(FETCH, 1'b1));
      end
      mem_ready = 1'b0;
      expCnt = 0;
   endtask

   // Sixteen back-to-back beq: the 4-bit counter wraps 15 -> 0
   task automatic test_back_to_back();
      int st[$]; logic [16:0] e;
      st = '{FETCH, DECODE, BEQ};
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < st.size(); i++) begin
            @(negedge clk);
            op = 7'b1100011; mem_ready = 1'b1;
            #1;
            e = expSig(st[i], 1'b1);
            compared++;
            if (sig !== e) begin
               mismatched++; $display("[TB] FAIL b2b_%0d_%0d got=%b want=%b", k, i, sig, e);
            end
            compared++;
            if (smRetiredCnt !== 4'(expCnt)) begin
               mismatched++; $display("[TB] FAIL b2b_smallcnt_%0d_%0d got=%0d want=%0d", k, i, smRetiredCnt, 4'(expCnt));
            end
            if (e[1]) expCnt++;
         end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      compared++;
      if (smRetiredCnt !== 4'd0) begin
         mismatched++; $display("[TB] FAIL b2b_wrap got=%0d want=0", smRetiredCnt);
      end
      compared++;
      if (retired_cnt !== 32'd16) begin
         mismatched++; $display("[TB] FAIL b2b_widecnt got=%0d want=16", retired_cnt);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      reset_n = 1'b0;
      mem_ready = 1'b0;
      op = 7'b0000000;
      test_reset();
      test_lw();
      test_sw_wait();
      test_alu();
      test_beq_jal();
      test_lui();
      test_trap();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
